// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encodings and default width.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/half_sub.sv
// Combinational half subtractor; two of these plus an OR form a full-subtract cell.
module half_sub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one bit per clock with a registered borrow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             bflop_q, borrow_q;
  logic             accept, last_bit;
  logic             d0, bo0, d_bit, bo1, bout;

  half_sub u_hs0 (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .diff   (d0),
    .borrow (bo0)
  );

  half_sub u_hs1 (
    .a      (d0),
    .b      (bflop_q),
    .diff   (d_bit),
    .borrow (bo1)
  );

  assign bout = bo0 | bo1;

  // A start is honoured in IDLE and in DONE (back-to-back), never during RUN.
  assign accept   = start && (state_q != ST_RUN);
  assign last_bit = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (last_bit) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bflop_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        cnt_q   <= '0;
        bflop_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        diff_q  <= {d_bit, diff_q[WIDTH-1:1]};
        cnt_q   <= cnt_q + CW'(1);
        bflop_q <= bout;
        if (last_bit) borrow_q <= bout;
      end
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: cycle model for WIDTH=8, exhaustive pass at WIDTH=4.
module tb_serial_subtractor;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow;
  logic [7:0] diff;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted start yields a result W clocks later.
  int         m_left;
  logic       m_done, m_valid, m_borrow;
  logic [7:0] m_a, m_b, m_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_valid  <= 1'b1;
      m_diff   <= '0;
      m_borrow <= 1'b0;
    end else if (m_left == 0 && start) begin
      m_a     <= a;
      m_b     <= b;
      m_left  <= W;
      m_done  <= 1'b0;
      m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_diff   <= m_a - m_b;
        m_borrow <= (m_a < m_b);
        m_valid  <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, m_left != 0);
      check("model_done", done, m_done);
      if (m_valid) begin
        check("model_diff", diff, m_diff);
        check("model_borrow", borrow, m_borrow);
      end
    end
  end

  // Waits (bounded) for done on the 8-bit DUT, sampling #1 after each rising edge.
  task automatic wait_done8(output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done4(output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_d, input logic exp_b);
    int  edges, bcnt;
    bit  ok;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    bcnt = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, ok, 1'b1);
    check({name, "_latency"}, edges + 1, 9);
    check({name, "_busy_cycles"}, bcnt, 8);
    check({name, "_diff"}, diff, exp_d);
    check({name, "_borrow"}, borrow, exp_b);
  endtask

  initial begin
    int  e;
    bit  ok;
    logic [7:0] p;
    logic [3:0] ea, eb;

    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow, 1'b0);
    check("rst_diff4", diff4, 4'h0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("t10m3", 8'd10, 8'd3, 8'd7, 1'b0);
    run_op("t3m10", 8'd3, 8'd10, 8'hF9, 1'b1);
    run_op("t0m1", 8'd0, 8'd1, 8'hFF, 1'b1);
    run_op("tffmff", 8'hFF, 8'hFF, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    check("hold_diff", diff, 8'h00);
    check("hold_borrow", borrow, 1'b0);
    check("hold_done", done, 1'b0);

    // start held high; operands change during RUN and must not be picked up early
    @(negedge clk);
    a = 8'd77;
    b = 8'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd200;
    b = 8'd55;
    wait_done8(e, ok);
    check("held1_seen", ok, 1'b1);
    check("held1_edges", e, 8);
    check("held1_diff", diff, 8'd65);
    check("held1_borrow", borrow, 1'b0);
    wait_done8(e, ok);
    check("held2_seen", ok, 1'b1);
    check("held2_edges", e, 9);
    check("held2_diff", diff, 8'd145);
    check("held2_borrow", borrow, 1'b0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // asynchronous reset in the middle of bit 4
    @(negedge clk);
    a = 8'd50;
    b = 8'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_borrow", borrow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op("t100m200", 8'd100, 8'd200, 8'd156, 1'b1);
    repeat (3) @(negedge clk);

    // exhaustive WIDTH=4, back-to-back starts
    @(negedge clk);
    a4 = 4'h0;
    b4 = 4'h0;
    start4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      p = 8'(i);
      ea = p[7:4];
      eb = p[3:0];
      @(posedge clk);
      #1;
      if (i < 255) begin
        p = 8'(i + 1);
        a4 = p[7:4];
        b4 = p[3:0];
      end else begin
        start4 = 1'b0;
      end
      wait_done4(e, ok);
      check("w4_edges", e, 4);
      check("w4_diff", diff4, 4'(ea - eb));
      check("w4_borrow", borrow4, ea < eb);
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
